// File: rtl/pack_pkg.sv
// Shared types and helpers for the beat-gathering pack stage and its idle timer.
package pack_pkg;

  typedef enum logic [0:0] {
    StCollect = 1'b0,
    StFull    = 1'b1
  } pack_state_e;

  // Counter width able to hold 0..limit; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Idle-cycle timer: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT-1. TIMEOUT=0 disables it entirely.
module pack_idle_timer
  import pack_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic exp
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clr, en};
    assign exp = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] Sat = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign exp = en && (cnt_q == Last);

    // Expiry restarts the count so a fresh partial word gets a full window.
    always_comb begin
      cnt_d = cnt_q;
      if (clr || exp) begin
        cnt_d = '0;
      end else if (en && (cnt_q != Sat)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/pack.sv
// Gathers ARGD consecutive ARGW-bit beats into one word, first beat in the
// least-significant lane; a stalled partial word is dropped after TIMEOUT idle clocks.
module pack
  import pack_pkg::*;
#(
  parameter int unsigned ARGW    = 8,
  parameter int unsigned ARGD    = 2,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_stb,
  input  logic [ARGW-1:0]      arg_dat,
  output logic                 arg_rdy,
  output logic                 out_stb,
  output logic [ARGW*ARGD-1:0] out_dat,
  input  logic                 out_rdy,
  output logic                 err
);

  localparam int unsigned IdxW = $clog2(ARGD);
  localparam int unsigned OutW = ARGW * ARGD;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ARGD - 1);

  pack_state_e     state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [OutW-1:0] dat_q, dat_d;
  logic            arg_rdy_q, arg_rdy_d;
  logic            out_stb_q, out_stb_d;
  logic            err_q, err_d;

  logic accept;
  logic emit;
  logic expire;
  logic timer_en;

  assign accept   = arg_stb & arg_rdy_q;
  assign emit     = out_stb_q & out_rdy;
  assign timer_en = (state_q == StCollect) && (idx_q != '0);

  pack_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (timer_en),
    .exp(expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    err_d   = 1'b0;
    unique case (state_q)
      StCollect: begin
        // A beat arriving on the expiry cycle wins over the timeout.
        if (accept) begin
          dat_d[idx_q*ARGW +: ARGW] = arg_dat;
          if (idx_q == LastIdx) begin
            state_d = StFull;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (expire) begin
          idx_d = '0;
          err_d = 1'b1;
        end
      end
      StFull: begin
        if (emit) begin
          state_d = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
    arg_rdy_d = (state_d == StCollect);
    out_stb_d = (state_d == StFull);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StCollect;
      idx_q     <= '0;
      dat_q     <= '0;
      arg_rdy_q <= 1'b0;
      out_stb_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dat_q     <= dat_d;
      arg_rdy_q <= arg_rdy_d;
      out_stb_q <= out_stb_d;
      err_q     <= err_d;
    end
  end

  assign arg_rdy = arg_rdy_q;
  assign out_stb = out_stb_q;
  assign out_dat = dat_q;
  assign err     = err_q;

endmodule
